// File: rtl/morse_pkg.sv
// Shared Morse definitions: decoder state encoding, the ten digit patterns
// (first symbol in the MSB, 1 = dash) and timing thresholds in dot units.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_GAP,
        ST_WORD,
        ST_RECOVER
    } morse_dec_state_t;

    localparam logic [4:0] PAT_1 = 5'b01111;
    localparam logic [4:0] PAT_2 = 5'b00111;
    localparam logic [4:0] PAT_3 = 5'b00011;
    localparam logic [4:0] PAT_4 = 5'b00001;
    localparam logic [4:0] PAT_5 = 5'b00000;
    localparam logic [4:0] PAT_6 = 5'b10000;
    localparam logic [4:0] PAT_7 = 5'b11000;
    localparam logic [4:0] PAT_8 = 5'b11100;
    localparam logic [4:0] PAT_9 = 5'b11110;
    localparam logic [4:0] PAT_0 = 5'b11111;

    localparam int DASH_MIN = 2;
    localparam int CHAR_GAP = 2;
    localparam int WORD_GAP = 5;
    localparam int MARK_MAX = 5;

    // Returns {valid, digit}; valid is 0 for any pattern outside the digit set.
    function automatic logic [4:0] decode_pat(input logic [4:0] pat);
        logic [4:0] res;
        res = 5'b0_0000;
        case (pat)
            PAT_1:   res = {1'b1, 4'd1};
            PAT_2:   res = {1'b1, 4'd2};
            PAT_3:   res = {1'b1, 4'd3};
            PAT_4:   res = {1'b1, 4'd4};
            PAT_5:   res = {1'b1, 4'd5};
            PAT_6:   res = {1'b1, 4'd6};
            PAT_7:   res = {1'b1, 4'd7};
            PAT_8:   res = {1'b1, 4'd8};
            PAT_9:   res = {1'b1, 4'd9};
            PAT_0:   res = {1'b1, 4'd0};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_line_cond.sv
// Input conditioning for the Morse line: 2-FF synchronizer, followed by a
// persistence filter of F cycles when F > 0 (F = 0 passes the synchronizer through).
module morse_line_cond #(
    parameter int F = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic morse_in,
    output logic line
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= morse_in;
            sync2 <= sync1;
        end
    end

    generate
        if (F > 0) begin : g_filt
            localparam int FW = $clog2(F + 1);
            logic [FW-1:0] run_cnt;
            logic          line_q;

            // A new level is adopted on its F-th consecutive cycle, so both
            // edges are delayed by the same F cycles and durations survive.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    line_q  <= 1'b0;
                    run_cnt <= '0;
                end else if (sync2 == line_q) begin
                    run_cnt <= '0;
                end else if (run_cnt == FW'(F - 1)) begin
                    line_q  <= sync2;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end

            assign line = line_q;
        end else begin : g_bypass
            assign line = sync2;
        end
    endgenerate

endmodule

// File: rtl/morse_code_decoder.sv
// Morse digit decoder: times marks/gaps on a synchronized line and strobes digits,
// errors and end-of-sequence. Define MORSE_DEC_GLITCH_FILTER_EN for the input glitch filter.
module morse_code_decoder
  import morse_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int UNIT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       error,
  output logic       seq_end,
  output logic       busy
);

  localparam int U  = CLK_HZ / 1000 * UNIT_MS;
  localparam int CW = $clog2(MARK_MAX * U + 1);
  localparam logic [CW-1:0] T_DASH = CW'(DASH_MIN * U);
  localparam logic [CW-1:0] T_CHAR = CW'(CHAR_GAP * U);
  localparam logic [CW-1:0] T_WORD = CW'(WORD_GAP * U);
  localparam logic [CW-1:0] T_MAX  = CW'(MARK_MAX * U);

`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam int FILT = U / 8;
`else
  localparam int FILT = 0;
`endif

  logic line;

  morse_line_cond #(.F(FILT)) u_line_cond (
    .clk      (clk),
    .rst      (rst),
    .morse_in (morse_in),
    .line     (line)
  );

  morse_dec_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [4:0]    pat, pat_nx, dec;
  logic [2:0]    n, n_nx;
  logic [3:0]    digit_nx;
  logic          dv_nx, err_nx, se_nx;

  // cnt holds the length of the current run of the line level, this cycle included.
  assign cnt_inc = (cnt == T_MAX) ? cnt : cnt + 1'b1;
  assign dec     = decode_pat(pat);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pat         <= '0;
      n           <= '0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      error       <= 1'b0;
      seq_end     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pat         <= pat_nx;
      n           <= n_nx;
      digit_out   <= digit_nx;
      digit_valid <= dv_nx;
      error       <= err_nx;
      seq_end     <= se_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pat_nx   = pat;
    n_nx     = n;
    digit_nx = digit_out;
    dv_nx    = 1'b0;
    err_nx   = 1'b0;
    se_nx    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (line) begin
          state_nx = ST_MARK;
          cnt_nx   = CW'(1);
          pat_nx   = '0;
          n_nx     = '0;
        end
      end
      ST_MARK: begin
        if (line) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == T_MAX) begin
            err_nx   = 1'b1;
            state_nx = ST_RECOVER;
            cnt_nx   = '0;
          end
        end else if (n == 3'd5) begin
          // Sixth symbol: the falling edge is already gap cycle 1.
          err_nx   = 1'b1;
          state_nx = ST_RECOVER;
          cnt_nx   = CW'(1);
        end else begin
          pat_nx   = {pat[3:0], (cnt >= T_DASH)};
          n_nx     = n + 3'd1;
          state_nx = ST_GAP;
          cnt_nx   = CW'(1);
        end
      end
      ST_GAP: begin
        if (line) begin
          state_nx = ST_MARK;
          cnt_nx   = CW'(1);
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == T_CHAR) begin
            state_nx = ST_WORD;
            if (n == 3'd5 && dec[4]) begin
              dv_nx    = 1'b1;
              digit_nx = dec[3:0];
            end else begin
              err_nx = 1'b1;
            end
          end
        end
      end
      ST_WORD: begin
        // Only reachable after a decode or an error, so seq_end is always owed here.
        if (line) begin
          state_nx = ST_MARK;
          cnt_nx   = CW'(1);
          pat_nx   = '0;
          n_nx     = '0;
        end else if (cnt_inc == T_WORD) begin
          se_nx    = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_RECOVER: begin
        if (line) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == T_CHAR) begin
            state_nx = ST_WORD;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_morse_code_decoder.sv
// Bench for morse_code_decoder: digit table, randomized characters against a
// symbol-level model, and hand-built timing corner cases.
module tb_morse_code_decoder;

  localparam int CLK_HZ  = 32_000;
  localparam int UNIT_MS = 1;
  localparam int U       = CLK_HZ / 1000 * UNIT_MS;
`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam int LAT = 1 + U / 8;
`else
  localparam int LAT = 1;
`endif
  localparam int K_DIGIT = 0;
  localparam int K_ERROR = 1;
  localparam int K_SEQ   = 2;
  localparam int T_DIG   = 0;
  localparam int T_ERR   = 1;
  localparam int T_SIX   = 2;

  typedef struct {
    string syms;
    int    kind;
    int    digit_after;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       morse_in = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       error;
  logic       seq_end;
  logic       busy;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_digit = 4'd0;
  logic [39:0] exp_q[$];
  vec_t       tbl[14];

  int          mon_n;
  int          mon_k;
  logic [39:0] mon_e;

  morse_code_decoder #(.CLK_HZ(CLK_HZ), .UNIT_MS(UNIT_MS)) dut (
    .clk         (clk),
    .rst         (rst),
    .morse_in    (morse_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .error       (error),
    .seq_end     (seq_end),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int at, input int kind, input int dig);
    exp_q.push_back({32'(at), 4'(kind), 4'(dig)});
  endtask

  // Index of the posedge that will first sample whatever is driven now.
  function automatic int nxt();
    return cyc + 1;
  endfunction

  // ---------------- reference model ----------------
  // Digits 1-5 are d dots then dashes; 6-9 are (d-5) dashes then dots; 0 is all dashes.
  function automatic string digit_str(input int d);
    string s;
    bit    dash;
    s = "";
    for (int i = 0; i < 5; i++) begin
      dash = (d == 0) || ((d <= 5) ? (i >= d) : (i < d - 5));
      s = {s, dash ? "-" : "."};
    end
    return s;
  endfunction

  task automatic model(input string s, output int kind, output int dig, output bit six);
    int  k;
    bit  ok;
    kind = K_ERROR;
    dig  = 0;
    six  = (s.len() > 5);
    if (s.len() == 5) begin
      k = 1;
      while (k < 5 && s[k] == s[0]) k++;
      ok = 1'b1;
      for (int i = k; i < 5; i++) if (s[i] == s[0]) ok = 1'b0;
      if (ok) begin
        kind = K_DIGIT;
        dig  = (s[0] == "-") ? (5 + k) % 10 : k;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    mon_n = int'(digit_valid) + int'(error) + int'(seq_end);
    if (mon_n > 1) check("strobe_overlap", mon_n, 1);
    if (mon_n != 0) begin
      mon_k = digit_valid ? K_DIGIT : (error ? K_ERROR : K_SEQ);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: actual kind=%0d required none (cycle %0d)", mon_k, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_cycle", cyc, int'(mon_e[39:8]));
        check("strobe_kind", mon_k, int'(mon_e[7:4]));
        if (int'(mon_e[7:4]) == K_DIGIT) exp_digit = mon_e[3:0];
        check("digit_out", int'(digit_out), int'(exp_digit));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input logic lvl, input int dur);
    morse_in = lvl;
    repeat (dur) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_marks(input string s, input int dot_len, input int dash_len,
                            input int igap, input bit rnd);
    int len;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "-") len = rnd ? int'($urandom_range(2 * U + 1, 5 * U - 2)) : dash_len;
      else             len = rnd ? int'($urandom_range(U / 4, 2 * U - 2)) : dot_len;
      run(1'b1, len);
      if (i != s.len() - 1) run(1'b0, rnd ? int'($urandom_range(U / 4, 2 * U - 2)) : igap);
    end
  endtask

  task automatic send_char(input string s, input int dot_len, input int dash_len,
                           input int igap, input int cgap, input bit rnd);
    int kind, dig, j0;
    bit six;
    model(s, kind, dig, six);
    send_marks(s, dot_len, dash_len, igap, rnd);
    j0 = nxt();
    if (six) push_exp(j0 + LAT + 1, K_ERROR, 0);
    else if (cgap >= 2 * U) push_exp(j0 + 2 * U + LAT, kind, dig);
    if (cgap >= 5 * U) push_exp(j0 + 5 * U + LAT, K_SEQ, 0);
    run(1'b0, cgap);
  endtask

  task automatic set_vec(input int i, input string s, input int k, input int d);
    tbl[i].syms        = s;
    tbl[i].kind        = k;
    tbl[i].digit_after = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation exceeded 100000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int j0, j1, nw, nc;
    string s;

    set_vec(0,  ".----",  T_DIG, 1);
    set_vec(1,  "..---",  T_DIG, 2);
    set_vec(2,  "...--",  T_DIG, 3);
    set_vec(3,  ".-.-.",  T_ERR, 3);
    set_vec(4,  "....-",  T_DIG, 4);
    set_vec(5,  ".....",  T_DIG, 5);
    set_vec(6,  "....",   T_ERR, 5);
    set_vec(7,  "-....",  T_DIG, 6);
    set_vec(8,  "--...",  T_DIG, 7);
    set_vec(9,  "-.-.-.", T_SIX, 7);
    set_vec(10, "---..",  T_DIG, 8);
    set_vec(11, "----.",  T_DIG, 9);
    set_vec(12, "--",     T_ERR, 9);
    set_vec(13, "-----",  T_DIG, 0);

    // reset state
    rst = 1'b0;
    morse_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digit_out", int'(digit_out), 0);
    check("rst_digit_valid", int'(digit_valid), 0);
    check("rst_error", int'(error), 0);
    check("rst_seq_end", int'(seq_end), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(1'b0, 4);

    // digit table at nominal timing, one character per word
    for (int i = 0; i < 14; i++) begin
      send_marks(tbl[i].syms, U, 3 * U, U, 1'b0);
      j0 = nxt();
      if (tbl[i].kind == T_SIX) push_exp(j0 + LAT + 1, K_ERROR, 0);
      else push_exp(j0 + 2 * U + LAT, (tbl[i].kind == T_DIG) ? K_DIGIT : K_ERROR,
                    tbl[i].digit_after);
      push_exp(j0 + 5 * U + LAT, K_SEQ, 0);
      run(1'b0, 6 * U);
      check("tbl_digit_out", int'(digit_out), tbl[i].digit_after);
      check("tbl_idle_busy", int'(busy), 0);
    end

    // dot/dash and intra-gap boundaries: 2U mark is a dash, 2U-1 is a dot
    send_char("-....", 2 * U - 1, 2 * U, 2 * U - 1, 6 * U, 1'b0);
    check("boundary_digit", int'(digit_out), 6);

    // gap hits 2U as the line rises, then word gap hits 5U as the line rises
    send_char(".....", U, 3 * U, U, 2 * U, 1'b0);
    send_char("-----", U, 3 * U, U, 5 * U, 1'b0);
    send_char("..---", U, 3 * U, U, 6 * U, 1'b0);
    check("collision_digit", int'(digit_out), 2);

    // overlong mark, then recovery into a valid character
    j1 = nxt();
    push_exp(j1 + 5 * U + LAT, K_ERROR, 0);
    run(1'b1, 6 * U);
    run(1'b0, 3 * U);
    send_char("-----", U, 3 * U, U, 6 * U, 1'b0);
    check("overlong_then_zero", int'(digit_out), 0);

`ifdef MORSE_DEC_GLITCH_FILTER_EN
    // 3-cycle glitches inside dashes and gaps must be invisible
    for (int i = 0; i < 5; i++) begin
      run(1'b1, U);
      run(1'b0, 3);
      run(1'b1, 2 * U - 3);
      if (i != 4) begin
        run(1'b0, U / 2);
        run(1'b1, 3);
        run(1'b0, U / 2 - 3);
      end
    end
    j0 = nxt();
    push_exp(j0 + 2 * U + LAT, K_DIGIT, 0);
    push_exp(j0 + 5 * U + LAT, K_SEQ, 0);
    run(1'b0, U);
    run(1'b1, 3);
    run(1'b0, 5 * U - 3);
    check("glitch_digit", int'(digit_out), 0);
`else
    // single-cycle marks are dots
    send_char(".....", 1, 3 * U, U, 6 * U, 1'b0);
    check("short_dot_digit", int'(digit_out), 5);
`endif

    // randomized words against the model
    for (int w = 0; w < 12; w++) begin
      nw = int'($urandom_range(1, 3));
      for (int c = 0; c < nw; c++) begin
        if ($urandom_range(0, 9) < 6) begin
          s = digit_str(int'($urandom_range(0, 9)));
        end else begin
          s = "";
          nc = int'($urandom_range(1, 6));
          for (int k = 0; k < nc; k++) s = {s, ($urandom_range(0, 1) == 1) ? "-" : "."};
        end
        send_char(s, 0, 0, 0,
                  (c == nw - 1) ? int'($urandom_range(5 * U + 1, 6 * U))
                                : int'($urandom_range(2 * U + 1, 5 * U - 2)),
                  1'b1);
      end
    end

    // reset mid-character discards it silently
    send_char("-----", U, 3 * U, U, 6 * U, 1'b0);
    send_marks("..", U, 3 * U, U, 1'b0);
    run(1'b0, U);
    run(1'b1, U / 2);
    @(negedge clk);
    check("mid_char_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    morse_in = 1'b0;
    @(posedge clk);
    exp_digit = 4'd0;
    @(negedge clk);
    check("midrst_digit_out", int'(digit_out), 0);
    check("midrst_digit_valid", int'(digit_valid), 0);
    check("midrst_error", int'(error), 0);
    check("midrst_seq_end", int'(seq_end), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(1'b0, 6 * U);
    send_char(".....", U, 3 * U, U, 6 * U, 1'b0);
    check("after_rst_digit", int'(digit_out), 5);

    run(1'b0, 2 * U);
    check("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
